// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO feeding a serializer one frame at a time,
// with TX status flags (empty, full, transmit-complete, overflow) for the register block.
module uart_tx_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          pClk,
  input  logic          pReset,
  input  logic          TxEn,
  input  logic          WrEn,
  input  logic [7:0]    WrData,
  input  logic          Flush,
  input  logic          TxcClr,
  input  logic          OvfClr,
  input  logic          TxDone,
  output logic          TxStart,
  output logic [7:0]    TxData,
  output logic          Empty,
  output logic          Full,
  output logic          Busy,
  output logic          TxComplete,
  output logic          Overflow,
  output logic [AW:0]   Level
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            txc_q, txc_d;
  logic            ovf_q, ovf_d;

  logic            empty_w, full_w;
  logic            pop, push, ovf_set, txc_set, done_to_idle;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == (AW+1)'(DEPTH));

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    done_to_idle = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!Flush && TxEn && !empty_w) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: state_d = S_BUSY;
      S_BUSY: begin
        if (TxDone) begin
          if (!Flush && TxEn && !empty_w) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d      = S_IDLE;
            done_to_idle = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push    = WrEn && !Flush && (!full_w || pop);
    ovf_set = WrEn && !Flush && full_w && !pop;
    // Flush leaves the FIFO empty, so a frame ending alongside it still completes.
    txc_set = done_to_idle && (empty_w || Flush) && !push;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;
    if (pop) begin
      tx_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    txc_d = txc_q;
    if (TxcClr || push) txc_d = 1'b0;
    else if (txc_set)   txc_d = 1'b1;

    ovf_d = ovf_q;
    if (ovf_set)     ovf_d = 1'b1;
    else if (OvfClr) ovf_d = 1'b0;
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= '0;
      txc_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
      txc_q     <= txc_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge pClk) begin
    if (push) mem_q[wr_ptr_q] <= WrData;
  end

  assign TxStart    = (state_q == S_START);
  assign Busy       = (state_q != S_IDLE);
  assign TxData     = tx_data_q;
  assign Empty      = empty_w;
  assign Full       = full_w;
  assign Level      = count_q;
  assign TxComplete = txc_q;
  assign Overflow   = ovf_q;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side controller between the APB register block and the UART serializer. Buffers bytes written to the TX data register in a small FIFO, sequences the serializer one frame at a time with a single-cycle start pulse, and keeps the TX status flags (empty, full, transmit-complete, overflow) that the register block reports in its status register.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- AW, 2, pointer width; equals log2(DEPTH)
- pClk  input  1  system clock; all state changes on its rising edge
- pReset  input  1  asynchronous reset, active-low
- TxEn  input  1  1 = new frames may be started; 0 = hold queued bytes
- WrEn  input  1  one-cycle push strobe from register block (APB write to TX data address)
- WrData  input  8  byte to push, sampled when WrEn = 1
- Flush  input  1  one-cycle strobe: discard all queued bytes
- TxcClr  input  1  one-cycle strobe: clear TxComplete
- OvfClr  input  1  one-cycle strobe: clear Overflow
- TxDone  input  1  one-cycle pulse from serializer: current frame finished (stop bit sent)
- TxStart  output  1  one-cycle pulse to serializer: begin frame with TxData
- TxData  output  8  byte under transmission; stable from TxStart until TxDone
- Empty  output  1  FIFO holds no bytes
- Full  output  1  FIFO holds DEPTH bytes
- Busy  output  1  a frame is in progress (state START or BUSY)
- TxComplete  output  1  sticky: last frame done and nothing queued (UART TXC)
- Overflow  output  1  sticky: a push was dropped
- Level  output  AW+1  bytes currently queued

## Operation
- Reset values: TxStart 0, TxData 8'h00, Empty 1, Full 0, Busy 0, TxComplete 0, Overflow 0, Level 0; pointers 0; state IDLE.
- FIFO: circular, write pointer and read pointer AW bits wrapping DEPTH-1 -> 0; count AW+1 bits. Empty = (count == 0), Full = (count == DEPTH), both registered-equivalent (derived from count only).
- Push: accepted when WrEn = 1 and (not Full, or a pop occurs the same cycle). Push while Full with no pop: byte dropped, Overflow set.
- Pop: performed by the FSM only; pop loads the head byte into TxData.
- States:
  - IDLE: if TxEn = 1 and not Empty -> pop, go START. Else stay.
  - START: TxStart = 1 for this cycle; go BUSY unconditionally.
  - BUSY: wait for TxDone. On TxDone: if TxEn = 1 and not Empty -> pop, go START (back-to-back frame); else go IDLE and set TxComplete if Empty and no push this cycle.
- TxDone in IDLE or START is ignored.
- TxEn = 0 never aborts a frame; it only blocks the next pop.
- Flush: count, read and write pointers return to 0 at next edge; Flush wins over a same-cycle push (byte discarded, no Overflow) and over a pop decision (FSM in IDLE stays IDLE; in BUSY with TxDone goes IDLE). Current frame in START/BUSY continues; TxData unchanged.
- TxComplete: set as above; cleared by TxcClr or by any accepted push; clear has priority over set in the same cycle.
- Overflow: cleared by OvfClr; a same-cycle set wins over OvfClr.

## Timing
- Push accepted at edge N: Empty falls, Level increments after edge N.
- From IDLE with TxEn = 1: pop at edge N+1, TxStart high during cycle N+1..N+2, TxData valid from edge N+1.
- Back-to-back: TxDone sampled at edge M -> TxStart high the cycle after edge M; zero idle cycles between frames.
- Level/Empty/Full update on the same edge as the push/pop that changes them; simultaneous push and pop leaves Level unchanged.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously); queued bytes lost.

## Test plan
- Single byte: push 8'hA5 with TxEn = 1 -> TxStart one cycle, two cycles after push edge, TxData = 8'hA5; TxDone -> Busy 0, TxComplete 1, Empty 1.
- Fill and drain: push 8'h01..8'h04 with TxEn = 0 -> Full 1, Level 4; fifth push 8'h05 -> Overflow 1, Level stays 4; set TxEn = 1 and pulse TxDone per frame -> TxData sequence 01,02,03,04, each TxStart the cycle after TxDone.
- Push while Full coinciding with pop (TxDone in BUSY, queue full) -> byte accepted, Level stays 4, Overflow stays 0.
- Flush mid-frame: 3 bytes queued, frame in BUSY, pulse Flush with a same-cycle push -> Level 0, Overflow 0, TxData unchanged; TxDone -> IDLE, TxComplete 1, no further TxStart.
- Sticky flags: TxcClr and set on the same cycle -> TxComplete 0; OvfClr with same-cycle overflow -> Overflow 1; a later push clears TxComplete.
- Reset during BUSY with 2 bytes queued -> all outputs at reset values, no TxStart after reset release until a new push.
